// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
//
// AHB-Lite slave that turns each 32-bit word transfer into one APB
// SETUP/ACCESS sequence toward a single APB slave (the SPI master). The AHB
// data phase is stretched with wait states until the APB access finishes. An
// APB slave error becomes the two-cycle AHB ERROR response. A transfer with an
// illegal size or alignment is answered with ERROR and never reaches APB.
//
// Ports
//   HCLK, HRESETn      shared clock, asynchronous active-low reset
//   HSEL, HADDR,
//   HTRANS, HWRITE,
//   HSIZE, HREADY      AHB address phase (HREADY qualifies the capture)
//   HWDATA             AHB write data (data phase)
//   HREADYOUT, HRESP,
//   HRDATA             AHB slave response
//   PADDR, PWDATA,
//   PWRITE, PSEL,
//   PENABLE            APB master request
//   PRDATA, PREADY,
//   PSLVERR            APB slave response
//
// Timing: address phase in cycle N, LATCH N+1, SETUP N+2, ACCESS N+3. A
// zero-wait APB slave completes at N+3 (two AHB wait states); each PREADY-low
// cycle in ACCESS adds one more.
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  // AHB-Lite slave
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [31:0]               HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic [31:0]               HRDATA,
  output logic                      HRESP,
  // APB master
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [31:0]               pwdata_q, pwdata_d;

  logic capture;
  logic legal;
  logic apb_ok;
  logic accept;

  // Only the low address bits reach APB and HTRANS[0] (SEQ vs NONSEQ) makes
  // no difference to a bridge that handles every beat as a single transfer.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:APB_ADDR_WIDTH], HTRANS[0]};

  // A valid AHB address phase aimed at this slave.
  assign capture = HSEL & HTRANS[1] & HREADY;

  // Only aligned 32-bit word transfers are supported.
  assign legal   = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);

  // ACCESS cycle in which the APB slave finishes without error.
  assign apb_ok  = (state_q == S_ACCESS) & PREADY & ~PSLVERR;

  // A new address phase is accepted only when this cycle also ends the
  // previous AHB data phase (HREADYOUT high): idle, second ERROR cycle, or
  // OKAY completion of an APB access.
  assign accept  = capture & ((state_q == S_IDLE) | (state_q == S_ERR2) | apb_ok);

  // -------------------------------------------------------------------------
  // State and APB request registers
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        // The master may already present the next transfer in the second
        // ERROR cycle, or cancel it with IDLE.
        if (capture) state_d = legal ? S_LATCH : S_ERR1;
        else         state_d = S_IDLE;
      end
      S_LATCH:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR)      state_d = S_ERR2;
          else if (capture) state_d = legal ? S_LATCH : S_ERR1;
          else              state_d = S_IDLE;
        end
      end
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end

  // Captured address/direction are updated only for legal transfers, so PADDR
  // and PWRITE never move on account of a transfer that is rejected. They stay
  // frozen from LATCH until the next accepted transfer, which keeps them stable
  // throughout SETUP and ACCESS.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    if (accept && legal) begin
      paddr_d  = HADDR[APB_ADDR_WIDTH-1:0];
      pwrite_d = HWRITE;
    end
    // HWDATA belongs to the AHB data phase, which is the LATCH cycle.
    if ((state_q == S_LATCH) && pwrite_q) begin
      pwdata_d = HWDATA;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state_q)
      S_LATCH: begin
        HREADYOUT = 1'b0;
      end
      S_SETUP: begin
        HREADYOUT = 1'b0;
        PSEL      = 1'b1;
      end
      S_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        // PSLVERR only matters together with PREADY; an erroring access
        // turns this cycle into the first (not-ready) ERROR cycle.
        HREADYOUT = PREADY & ~PSLVERR;
        HRESP     = PREADY & PSLVERR;
        if (apb_ok && !pwrite_q) begin
          HRDATA = PRDATA;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: begin
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge
//
// Cycle-based AHB-Lite master plus APB slave around ahb_apb_bridge. Each
// transfer carries the APB slave behaviour it will meet (wait count, error).
// The expected AHB response (cycle count, HRESP, HRDATA) is derived from the
// transfer alone; a word memory at AHB level supplies expected read data.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge;

  localparam int AW = 12;

  logic          HCLK;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  // Single-slave system: the bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  ahb_apb_bridge #(.APB_ADDR_WIDTH(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;   // PREADY-low cycles the APB slave inserts
    logic        err;     // APB slave answers with PSLVERR
    int          gap;     // idle cycles before the address phase
  } txn_t;

  txn_t        stim[$];
  txn_t        apb_q[$];
  txn_t        ap_txn;
  txn_t        dp_txn;
  bit          ap_valid;
  bit          dp_valid;
  int          dp_cycles;
  int          acc_cnt;
  int          gap_cnt;
  bit          hready_s;
  logic [31:0] ref_mem [1024];
  logic [31:0] slv_mem [1024];
  int          n_chk;
  int          n_pass;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic bit is_legal(txn_t t);
    return (t.size == 3'b010) && (t.addr[1:0] == 2'b00);
  endfunction

  // Data-phase length including the final HREADYOUT-high cycle.
  function automatic int exp_cycles(txn_t t);
    if (!is_legal(t)) return 2;
    return 3 + t.waits + (t.err ? 1 : 0);
  endfunction

  function automatic txn_t mk(logic [31:0] addr, logic write, logic [2:0] size,
                              logic [31:0] wdata, int waits, logic err, int gap);
    txn_t t;
    t.addr = addr; t.write = write; t.size = size; t.wdata = wdata;
    t.waits = waits; t.err = err; t.gap = gap;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr       = $urandom;
    t.addr[11:0] = 12'($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 9) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
    t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
    t.write = 1'($urandom);
    t.wdata = $urandom;
    t.waits = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
    t.err   = ($urandom_range(0, 7) == 0);
    t.gap   = $urandom_range(0, 2);
    return t;
  endfunction

  // One clock: drive just after the rising edge, check on the falling edge,
  // then advance the master/slave bookkeeping across the next rising edge.
  task automatic run_cycle();
    txn_t c;
    bit   done;
    bit   acc_wait;
    bit   leg;
    bit   xerr;
    int   tot;
    int   idx;

    if (ap_valid) begin
      HSEL   = 1'b1;
      HTRANS = {1'b1, 1'($urandom)};
      HADDR  = ap_txn.addr;
      HWRITE = ap_txn.write;
      HSIZE  = ap_txn.size;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin HSEL = 1'b0; HTRANS = 2'($urandom); end
        1:       begin HSEL = 1'b1; HTRANS = 2'b00;        end
        default: begin HSEL = 1'b1; HTRANS = 2'b01;        end
      endcase
      HADDR  = $urandom;
      HWRITE = 1'($urandom);
      HSIZE  = 3'($urandom);
    end
    HWDATA = (dp_valid && dp_txn.write) ? dp_txn.wdata : $urandom;

    if (PSEL && PENABLE && apb_q.size() > 0) begin
      PREADY  = (acc_cnt >= apb_q[0].waits);
      PSLVERR = PREADY ? apb_q[0].err : 1'($urandom);
      PRDATA  = slv_mem[PADDR[11:2]];
    end else begin
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
    end

    @(negedge HCLK);
    done = 1'b0;

    if (PSEL && PENABLE && PREADY) begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected_access", 32'(PSEL), 32'h0);
      end else begin
        c = apb_q.pop_front();
        chk("paddr", 32'(PADDR), 32'(c.addr[AW-1:0]));
        chk("pwrite", 32'(PWRITE), 32'(c.write));
        if (c.write) begin
          chk("pwdata", PWDATA, c.wdata);
          if (!c.err) slv_mem[PADDR[11:2]] = PWDATA;
        end
      end
    end

    if (dp_valid) begin
      dp_cycles++;
      tot  = exp_cycles(dp_txn);
      leg  = is_legal(dp_txn);
      xerr = !leg || dp_txn.err;
      idx  = int'(dp_txn.addr[11:2]);
      chk("hreadyout", 32'(HREADYOUT), 32'(dp_cycles == tot));
      if (HREADYOUT) begin
        chk("hresp", 32'(HRESP), 32'(xerr));
        if (leg && !dp_txn.write && !xerr) chk("hrdata", HRDATA, ref_mem[idx]);
        else                               chk("hrdata_zero", HRDATA, 32'h0);
        if (xerr) chk("psel_in_err2", 32'(PSEL), 32'h0);
        if (leg && dp_txn.write && !xerr) ref_mem[idx] = dp_txn.wdata;
        done = 1'b1;
      end else begin
        chk("hresp_wait", 32'(HRESP), 32'(xerr && (dp_cycles == tot - 1)));
      end
    end else begin
      chk("idle_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("idle_hresp", 32'(HRESP), 32'h0);
    end

    hready_s = HREADYOUT;
    acc_wait = PSEL && PENABLE && !PREADY;

    @(posedge HCLK);
    #1;
    if (acc_wait) acc_cnt++;
    else          acc_cnt = 0;
    if (done) dp_valid = 1'b0;
    if (hready_s) begin
      if (ap_valid) begin
        dp_txn    = ap_txn;
        dp_valid  = 1'b1;
        dp_cycles = 0;
        if (is_legal(ap_txn)) apb_q.push_back(ap_txn);
      end
      ap_valid = 1'b0;
      if (stim.size() > 0) begin
        if (gap_cnt < stim[0].gap) gap_cnt++;
        else begin
          ap_txn   = stim.pop_front();
          ap_valid = 1'b1;
          gap_cnt  = 0;
        end
      end
    end
  endtask

  task automatic run_all(int budget);
    int n;
    n = 0;
    while ((stim.size() > 0 || ap_valid || dp_valid) && n < budget) begin
      run_cycle();
      n++;
    end
    chk("drain", 32'(stim.size() > 0 || ap_valid || dp_valid), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int          k;
    logic [31:0] wd;

    n_chk = 0; n_pass = 0;
    ap_valid = 1'b0; dp_valid = 1'b0; dp_cycles = 0;
    acc_cnt = 0; gap_cnt = 0; hready_s = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'hA5A5_0042;
    slv_mem[0] = 32'hA5A5_0042;

    HRESETn = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0004; HWRITE = 1'b1;
    HSIZE = 3'b010; HWDATA = 32'h1234_5678;
    PRDATA = 32'hDEAD_BEEF; PREADY = 1'b1; PSLVERR = 1'b1;
    #12;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_pwrite", 32'(PWRITE), 32'h0);
    chk("rst_paddr", 32'(PADDR), 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    HSEL = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Directed transfers: single write, slow read, APB error, illegal size,
    // then a back-to-back write/read pair.
    stim.push_back(mk(32'h0000_0004, 1'b1, 3'b010, 32'h0000_0013, 0, 1'b0, 1));
    stim.push_back(mk(32'h0000_0000, 1'b0, 3'b010, 32'h0,         3, 1'b0, 1));
    stim.push_back(mk(32'h0000_0010, 1'b0, 3'b010, 32'h0,         0, 1'b1, 1));
    stim.push_back(mk(32'h0000_0008, 1'b1, 3'b000, 32'h0000_0077, 0, 1'b0, 1));
    stim.push_back(mk(32'h0000_0008, 1'b1, 3'b010, 32'hCAFE_0008, 0, 1'b0, 1));
    stim.push_back(mk(32'h0000_0000, 1'b0, 3'b010, 32'h0,         0, 1'b0, 0));
    run_all(200);

    for (int i = 0; i < 200; i++) stim.push_back(rand_txn());
    run_all(5000);

    // Reset while an APB access is stalled in ACCESS.
    stim.push_back(mk(32'h0000_000C, 1'b0, 3'b010, 32'h0, 30, 1'b0, 0));
    seen = 1'b0;
    k = 0;
    while (!seen && k < 10) begin
      run_cycle();
      seen = PSEL && PENABLE;
      k++;
    end
    chk("access_reached", 32'(seen), 32'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midrst_psel", 32'(PSEL), 32'h0);
    chk("midrst_penable", 32'(PENABLE), 32'h0);
    chk("midrst_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("midrst_hresp", 32'(HRESP), 32'h0);
    ap_valid = 1'b0; dp_valid = 1'b0; acc_cnt = 0; gap_cnt = 0; hready_s = 1'b1;
    apb_q.delete();
    stim.delete();
    HSEL = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    wd = $urandom;
    stim.push_back(mk(32'h0000_000C, 1'b1, 3'b010, wd,   0, 1'b0, 0));
    stim.push_back(mk(32'h0000_000C, 1'b0, 3'b010, 32'h0, 1, 1'b0, 0));
    run_all(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- AHB-Lite slave to single-slave APB master bridge, placed directly upstream of the APB SPI master.
- Its APB outputs drive that block's PADDR/PWDATA/PSEL/PENABLE/PWRITE inputs, and it consumes PRDATA/PREADY/PSLVERR.
- Converts each 32-bit AHB word transfer into one APB SETUP/ACCESS sequence, inserts AHB wait states, and maps PSLVERR to a two-cycle AHB ERROR response.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR. PADDR is taken from the low bits of the captured HADDR.

Ports:
- HCLK  in  1  single clock for both AHB and APB sides.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  AHB slave select.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HWRITE  in  1  1 write, 0 read.
- HSIZE  in  3  transfer size; only 3'b010 is legal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready, used to qualify the address phase.
- HREADYOUT  out  1  slave ready.
- HRDATA  out  32  read data.
- HRESP  out  1  0 OKAY, 1 ERROR.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (async, active-low): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. A reset asserted mid-transfer drops PSEL/PENABLE immediately; no completion is reported.
- Address-phase capture:
  - Condition: HSEL & HTRANS[1] & HREADY.
  - Registers HADDR, HWRITE, and a legality flag.
  - Legal = HSIZE==3'b010 and HADDR[1:0]==2'b00.
- IDLE/BUSY transfers, and cycles with HSEL=0: no state change, zero-wait OKAY.
- States: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - Legal capture -> LATCH.
  - Illegal capture -> ERR1, with no APB access.
- LATCH:
  - HREADYOUT=0.
  - Registers HWDATA into PWDATA (writes only; PWDATA unchanged on reads).
  - Drives PADDR=HADDR_q[APB_ADDR_WIDTH-1:0] and PWRITE=HWRITE_q.
  - -> SETUP.
- SETUP: PSEL=1, PENABLE=0, HREADYOUT=0 -> ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - PREADY=0: stay, HREADYOUT=0.
  - PREADY=1, PSLVERR=0: HREADYOUT=1, HRESP=0. On a read, HRDATA=PRDATA (combinational, this cycle only; otherwise HRDATA=0). Next state: LATCH if a new legal capture happens in the same cycle, ERR1 if an illegal one, else IDLE.
  - PREADY=1, PSLVERR=1: HREADYOUT=0, HRESP=1 -> ERR2. This cycle is the first ERROR cycle; APB is released on the next edge.
- ERR1: HRESP=1, HREADYOUT=0, PSEL=0 -> ERR2.
- ERR2:
  - HRESP=1, HREADYOUT=1.
  - Capture is allowed in this cycle (the master may have cancelled with IDLE). Legal capture -> LATCH, illegal -> ERR1, else IDLE.
- PSLVERR is sampled only when PSEL & PENABLE & PREADY.
- Latency: address phase at cycle N. LATCH at N+1, SETUP at N+2, ACCESS at N+3. With zero-wait PREADY the OKAY completion is at N+3, giving 2 AHB wait states minimum. Each PREADY-low cycle adds one wait.
- Back-to-back transfers: every transfer pays the full LATCH/SETUP/ACCESS cost. PSEL deasserts for exactly the LATCH cycle between transfers.

Test Plan:
- Write HADDR=0x004, HWDATA=0x0000_0013, PREADY=1 -> PADDR=0x004, PWDATA=0x13, PWRITE=1, PSEL high 2 cycles, PENABLE 1 cycle. HREADYOUT low 2 cycles then high, HRESP=0.
- Read HADDR=0x000 with PREADY low 3 ACCESS cycles, PRDATA=0xA5A5_0042 -> HREADYOUT low 5 cycles, then HRDATA=0xA5A5_0042 on the completion cycle, HRESP=0.
- Read with PREADY=1 and PSLVERR=1 -> HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1. PSEL=0 in ERR2.
- HSIZE=3'b000 write to 0x008 -> no PSEL pulse; ERR1 then ERR2 response.
- Back-to-back NONSEQ write 0x008 then read 0x000 -> second address captured on the first completion cycle; PSEL low one cycle; both complete OKAY with correct PADDR.
- HRESETn low during ACCESS -> PSEL=PENABLE=0 and HREADYOUT=1 immediately. The next transfer after reset completes normally.
